addsub_scheduler: RTL

ADDSUB_SCHEDULER -- requirements
Module: addsub_scheduler

---
 rtl/addsub_scheduler_pkg.sv | 23 ++
 rtl/addsub_scheduler_rr_arbiter.sv | 48 ++++
 rtl/addsub_scheduler.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/addsub_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addsub_scheduler_pkg
// Description : Shared definitions for the add/subtract scheduler.
//               - Result-register controller state encoding (EMPTY=0, FULL=1)
//               - Default operand width, requester count and index width
// Revision    : 1.0 - initial release
// ============================================================================
package addsub_scheduler_pkg;

  // Default geometry of the shared adder/subtractor.
  localparam int C_DATA_WIDTH_DEF = 16;
  localparam int C_NUM_REQ_DEF    = 4;
  localparam int C_ID_W_DEF       = 2;

  // Result register occupancy. EMPTY means rsp_valid is low.
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage : addsub_scheduler_pkg
`default_nettype wire

// File: rtl/addsub_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. The search starts at
//               requester 'ptr' and wraps from NUM_REQ-1 to 0; the first
//               requester found with its req bit set wins.
// Ports       : req       - request vector, one bit per requester
//               ptr       - requester index where the search starts
//               grant     - one-hot grant (all zero when nobody requests)
//               grant_idx - index of the granted requester (0 when none)
//               grant_any - a grant was issued
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import addsub_scheduler_pkg::*;
#(
  parameter int NUM_REQ = C_NUM_REQ_DEF,
  parameter int ID_W    = C_ID_W_DEF
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  // Walk the requesters in priority order starting at ptr. The position is
  // wrapped with a single subtraction because ptr is always below NUM_REQ.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      int pos;
      pos = int'(ptr) + off;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      if (!grant_any && req[pos]) begin
        grant[pos] = 1'b1;
        grant_idx  = ID_W'(pos);
        grant_any  = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/addsub_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : addsub_scheduler
// Description : Shares one ripple adder/subtractor between NUM_REQ
//               requesters. A round-robin arbiter picks at most one
//               requester per cycle; its operation is computed
//               combinationally and captured in a single result register,
//               so the result appears one cycle after acceptance.
// Ports       : clk          - clock, all state on rising edge
//               rst_n        - asynchronous active-low reset
//               req_valid    - per-requester operation pending
//               req_ready    - per-requester accept (one-hot or zero)
//               req_a/req_b  - packed operands, slice i for requester i
//               req_sub      - per-requester: 1 = A-B, 0 = A+B
//               rsp_valid    - result register holds a result
//               rsp_ready    - consumer takes the result this cycle
//               rsp_id       - requester that owns the result
//               rsp_result   - wrapped sum/difference
//               rsp_overflow - signed overflow of that operation
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_scheduler
  import addsub_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = C_DATA_WIDTH_DEF,
  parameter int NUM_REQ    = C_NUM_REQ_DEF,
  parameter int ID_W       = C_ID_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]            req_sub,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_result,
  output logic                          rsp_overflow
);

  state_e                r_state;
  logic [ID_W-1:0]       r_ptr;
  logic [ID_W-1:0]       r_id;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_ovf;

  logic                  w_can_grant;
  logic [NUM_REQ-1:0]    w_req_masked;
  logic [NUM_REQ-1:0]    w_grant;
  logic [ID_W-1:0]       w_grant_idx;
  logic                  w_grant_any;
  logic [ID_W-1:0]       w_ptr_nxt;

  logic [DATA_WIDTH-1:0] w_a_sel [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_b_sel [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_a;
  logic [DATA_WIDTH-1:0] w_b;
  logic                  w_sub;
  logic [DATA_WIDTH-1:0] w_b_eff;
  logic [DATA_WIDTH-1:0] w_sum;
  logic [DATA_WIDTH-1:0] w_carry;
  logic                  w_ovf;

  // --------------------------------------------------------------------------
  // Arbitration. Requests are only offered to the arbiter when the result
  // register can accept a new value this cycle, and never during reset, so
  // req_ready is low whenever no transfer can happen.
  // --------------------------------------------------------------------------
  assign w_can_grant  = (r_state == ST_EMPTY) || rsp_ready;
  assign w_req_masked = req_valid & {NUM_REQ{w_can_grant & rst_n}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req       (w_req_masked),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .grant_any (w_grant_any)
  );

  assign req_ready = w_grant;
  assign w_ptr_nxt = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

  // --------------------------------------------------------------------------
  // Operand selection: AND-OR mux driven by the one-hot grant, so an
  // ungranted requester's operands never reach the adder.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sel
    assign w_a_sel[gi] = w_grant[gi] ? req_a[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign w_b_sel[gi] = w_grant[gi] ? req_b[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_a = w_a | w_a_sel[i];
      w_b = w_b | w_b_sel[i];
    end
  end

  assign w_sub = |(w_grant & req_sub);

  // --------------------------------------------------------------------------
  // Shared ripple adder/subtractor: A + (B ^ sub) + sub. The carry out of the
  // top bit is not needed, so the chain stops one stage short.
  // --------------------------------------------------------------------------
  assign w_b_eff    = w_b ^ {DATA_WIDTH{w_sub}};
  assign w_carry[0] = w_sub;

  for (genvar gb = 0; gb < DATA_WIDTH; gb++) begin : g_ripple
    assign w_sum[gb] = w_a[gb] ^ w_b_eff[gb] ^ w_carry[gb];
    if (gb < DATA_WIDTH - 1) begin : g_carry
      assign w_carry[gb+1] = (w_a[gb] & w_b_eff[gb]) |
                             (w_carry[gb] & (w_a[gb] ^ w_b_eff[gb]));
    end
  end

  // Signed overflow: operands of equal sign yielding a result of the other sign.
  assign w_ovf = (w_a[DATA_WIDTH-1] == w_b_eff[DATA_WIDTH-1]) &&
                 (w_sum[DATA_WIDTH-1] != w_a[DATA_WIDTH-1]);

  // --------------------------------------------------------------------------
  // Result-register controller. A grant always loads the register, which
  // covers both EMPTY->FULL and the back-to-back FULL->FULL case.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_EMPTY;
      r_ptr    <= '0;
      r_id     <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_grant_any) begin
        r_ptr    <= w_ptr_nxt;
        r_id     <= w_grant_idx;
        r_result <= w_sum;
        r_ovf    <= w_ovf;
      end
      case (r_state)
        ST_EMPTY: if (w_grant_any) r_state <= ST_FULL;
        ST_FULL:  if (rsp_ready && !w_grant_any) r_state <= ST_EMPTY;
        default:  r_state <= ST_EMPTY;
      endcase
    end
  end

  assign rsp_valid    = (r_state == ST_FULL);
  assign rsp_id       = r_id;
  assign rsp_result   = r_result;
  assign rsp_overflow = r_ovf;

endmodule : addsub_scheduler
`default_nettype wire
